// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard detection, branch squash and EX operand forwarding for the RV32 pipeline.
// Producers are tracked in a STAGES-deep scoreboard that shifts with the pipeline.

module phc_src_match #(
    parameter int REG_AW = 5
) (
    input  logic              wr_vld,
    input  logic [REG_AW-1:0] rd,
    input  logic              use_a,
    input  logic [REG_AW-1:0] src_a,
    input  logic              use_b,
    input  logic [REG_AW-1:0] src_b,
    output logic              hit_a,
    output logic              hit_b
);
    logic writer;

    // rd != 0 already excludes x0 sources, so src != 0 needs no separate term
    assign writer = wr_vld & (rd != '0);
    assign hit_a  = writer & use_a & (src_a == rd);
    assign hit_b  = writer & use_b & (src_b == rd);
endmodule

module pipe_hazard_ctrl #(
    parameter int STAGES     = 3,
    parameter int REG_AW     = 5,
    parameter int FWD_EN     = 1,
    parameter int LOAD_READY = 2,
    parameter int BR_STAGE   = 1,
    parameter int RF_WT      = 1,
    parameter int CNT_W      = 16,
    localparam int FW        = $clog2(STAGES + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              BUSYWAIT,
    input  logic              ID_VALID,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic              ID_USE_RS1,
    input  logic              ID_USE_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_REG_WRITE,
    input  logic              ID_MEM_READ,
    input  logic              BRANCH_TAKEN,
    output logic              STALL,
    output logic              FLUSH,
    output logic [FW-1:0]     FWD_A,
    output logic [FW-1:0]     FWD_B,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } dst_t;

    logic [STAGES-1:0]     vld_pipe;
    dst_t [STAGES-1:0]     dst_pipe;

    // Source fields are only ever consulted while the instruction sits in EX,
    // so they are kept for entry 0 only instead of riding the whole pipe.
    logic [REG_AW-1:0]     ex_rs1, ex_rs2;
    logic                  ex_u1, ex_u2;

    logic [STAGES-1:0]     id_hit1, id_hit2;
    logic [STAGES-1:1]     ex_hit1, ex_hit2;
    logic                  stall_raw;

    for (genvar i = 0; i < STAGES; i++) begin : g_id
        phc_src_match #(.REG_AW(REG_AW)) u_id (
            .wr_vld (vld_pipe[i] & dst_pipe[i].wr),
            .rd     (dst_pipe[i].rd),
            .use_a  (ID_USE_RS1),
            .src_a  (ID_RS1),
            .use_b  (ID_USE_RS2),
            .src_b  (ID_RS2),
            .hit_a  (id_hit1[i]),
            .hit_b  (id_hit2[i])
        );
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_ex
        phc_src_match #(.REG_AW(REG_AW)) u_ex (
            .wr_vld (vld_pipe[k] & dst_pipe[k].wr),
            .rd     (dst_pipe[k].rd),
            .use_a  (vld_pipe[0] & ex_u1),
            .src_a  (ex_rs1),
            .use_b  (vld_pipe[0] & ex_u2),
            .src_b  (ex_rs2),
            .hit_a  (ex_hit1[k]),
            .hit_b  (ex_hit2[k])
        );
    end

    always_comb begin
        stall_raw = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (FWD_EN == 0) begin
                // write-through RF lets ID read the WB result directly
                if ((i < STAGES - 1) || (RF_WT == 0))
                    stall_raw = stall_raw | id_hit1[i] | id_hit2[i];
            end else begin
                if (dst_pipe[i].ld && (i + 1 < LOAD_READY))
                    stall_raw = stall_raw | id_hit1[i] | id_hit2[i];
                // WB producer leaves the forward network before ID reaches EX
                if ((RF_WT == 0) && (i == STAGES - 1))
                    stall_raw = stall_raw | id_hit1[i] | id_hit2[i];
            end
        end
    end

    assign FLUSH = BRANCH_TAKEN & RESET;
    assign STALL = stall_raw & ID_VALID & ~FLUSH & RESET;

    // descending scan so the youngest (lowest index) producer wins
    always_comb begin
        FWD_A = '0;
        FWD_B = '0;
        if (FWD_EN != 0) begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                if (ex_hit1[k]) FWD_A = FW'(k);
                if (ex_hit2[k]) FWD_B = FW'(k);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            vld_pipe  <= '0;
            dst_pipe  <= '0;
            ex_rs1    <= '0;
            ex_rs2    <= '0;
            ex_u1     <= 1'b0;
            ex_u2     <= 1'b0;
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else if (!BUSYWAIT) begin
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~(FLUSH & ((i - 1) < BR_STAGE));
                dst_pipe[i] <= dst_pipe[i-1];
            end
            vld_pipe[0] <= ID_VALID & ~STALL & ~FLUSH;
            dst_pipe[0] <= '{rd: ID_RD, wr: ID_REG_WRITE, ld: ID_MEM_READ};
            ex_rs1      <= ID_RS1;
            ex_rs2      <= ID_RS2;
            ex_u1       <= ID_USE_RS1;
            ex_u2       <= ID_USE_RS2;
            if (STALL && (STALL_CNT != {CNT_W{1'b1}}))
                STALL_CNT <= STALL_CNT + 1'b1;
            if (FLUSH && (FLUSH_CNT != {CNT_W{1'b1}}))
                FLUSH_CNT <= FLUSH_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives four differently configured hazard units with shared stimulus and
// scoreboards them against an instruction-level model of the hazard rules.

module tb_pipe_hazard_ctrl;
    localparam int NC = 4;
    localparam int C_STAGES [NC] = '{3, 3, 3, 4};
    localparam int C_FWD    [NC] = '{1, 0, 1, 1};
    localparam int C_LR     [NC] = '{2, 2, 2, 3};
    localparam int C_BR     [NC] = '{1, 1, 1, 2};
    localparam int C_RFWT   [NC] = '{1, 1, 1, 0};
    localparam int C_CNTW   [NC] = '{16, 16, 2, 8};

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_n = 1'b0, busy = 1'b0, id_valid = 1'b0, bt = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       u1 = 1'b0, u2 = 1'b0, wr = 1'b0, ld = 1'b0;

    logic [3:0]       a_st, a_fl;
    logic [3:0][2:0]  a_fa, a_fb;
    logic [3:0][15:0] a_sc, a_fc;

    logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
    logic [2:0]  fa3, fb3;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [1:0]  sc2, fc2;
    logic [7:0]  sc3, fc3;

    pipe_hazard_ctrl #(.STAGES(3), .FWD_EN(1), .LOAD_READY(2), .BR_STAGE(1), .RF_WT(1), .CNT_W(16)) d0 (
        .CLK(CLK), .RESET(rst_n), .BUSYWAIT(busy), .ID_VALID(id_valid), .ID_RS1(rs1), .ID_RS2(rs2),
        .ID_USE_RS1(u1), .ID_USE_RS2(u2), .ID_RD(rd), .ID_REG_WRITE(wr), .ID_MEM_READ(ld),
        .BRANCH_TAKEN(bt), .STALL(a_st[0]), .FLUSH(a_fl[0]), .FWD_A(fa0), .FWD_B(fb0),
        .STALL_CNT(sc0), .FLUSH_CNT(fc0));
    pipe_hazard_ctrl #(.STAGES(3), .FWD_EN(0), .LOAD_READY(2), .BR_STAGE(1), .RF_WT(1), .CNT_W(16)) d1 (
        .CLK(CLK), .RESET(rst_n), .BUSYWAIT(busy), .ID_VALID(id_valid), .ID_RS1(rs1), .ID_RS2(rs2),
        .ID_USE_RS1(u1), .ID_USE_RS2(u2), .ID_RD(rd), .ID_REG_WRITE(wr), .ID_MEM_READ(ld),
        .BRANCH_TAKEN(bt), .STALL(a_st[1]), .FLUSH(a_fl[1]), .FWD_A(fa1), .FWD_B(fb1),
        .STALL_CNT(sc1), .FLUSH_CNT(fc1));
    pipe_hazard_ctrl #(.STAGES(3), .FWD_EN(1), .LOAD_READY(2), .BR_STAGE(1), .RF_WT(1), .CNT_W(2)) d2 (
        .CLK(CLK), .RESET(rst_n), .BUSYWAIT(busy), .ID_VALID(id_valid), .ID_RS1(rs1), .ID_RS2(rs2),
        .ID_USE_RS1(u1), .ID_USE_RS2(u2), .ID_RD(rd), .ID_REG_WRITE(wr), .ID_MEM_READ(ld),
        .BRANCH_TAKEN(bt), .STALL(a_st[2]), .FLUSH(a_fl[2]), .FWD_A(fa2), .FWD_B(fb2),
        .STALL_CNT(sc2), .FLUSH_CNT(fc2));
    pipe_hazard_ctrl #(.STAGES(4), .FWD_EN(1), .LOAD_READY(3), .BR_STAGE(2), .RF_WT(0), .CNT_W(8)) d3 (
        .CLK(CLK), .RESET(rst_n), .BUSYWAIT(busy), .ID_VALID(id_valid), .ID_RS1(rs1), .ID_RS2(rs2),
        .ID_USE_RS1(u1), .ID_USE_RS2(u2), .ID_RD(rd), .ID_REG_WRITE(wr), .ID_MEM_READ(ld),
        .BRANCH_TAKEN(bt), .STALL(a_st[3]), .FLUSH(a_fl[3]), .FWD_A(fa3), .FWD_B(fb3),
        .STALL_CNT(sc3), .FLUSH_CNT(fc3));

    always_comb begin
        a_fa = {fa3, 1'b0, fa2, 1'b0, fa1, 1'b0, fa0};
        a_fb = {fb3, 1'b0, fb2, 1'b0, fb1, 1'b0, fb0};
        a_sc = {8'b0, sc3, 14'b0, sc2, sc1, sc0};
        a_fc = {8'b0, fc3, 14'b0, fc2, fc1, fc0};
    end

    // ---------------- reference model: list of in-flight instructions ----------------
    typedef struct {
        bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
    } ent_t;

    ent_t m [NC][8];
    int   m_sc [NC];
    int   m_fc [NC];

    typedef struct packed {
        logic [3:0]       st, fl;
        logic [3:0][2:0]  fa, fb;
        logic [3:0][15:0] sc, fc;
    } exp_t;
    exp_t q[$];

    int checks = 0, failures = 0;

    function automatic bit prod(int c, int i, int s);
        return m[c][i].v && m[c][i].wr && (m[c][i].rd != 0) && (m[c][i].rd == s);
    endfunction

    // A value becomes usable by the EX consumer once its producer reaches 'avail'.
    function automatic bit mdl_stall(int c);
        int s, avail;
        bit us;
        if (!rst_n || !id_valid || bt) return 1'b0;
        for (int src = 0; src < 2; src++) begin
            s  = (src == 0) ? int'(rs1) : int'(rs2);
            us = (src == 0) ? u1 : u2;
            if (!us || s == 0) continue;
            for (int i = 0; i < C_STAGES[c]; i++) begin
                if (!prod(c, i, s)) continue;
                avail = (C_FWD[c] == 0) ? C_STAGES[c] : (m[c][i].ld ? C_LR[c] : 1);
                if (i + 1 < avail) return 1'b1;
                if (C_RFWT[c] == 0 && i == C_STAGES[c] - 1) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int mdl_fwd(int c, int src);
        int s;
        bit us;
        if (!rst_n || C_FWD[c] == 0 || !m[c][0].v) return 0;
        s  = (src == 0) ? m[c][0].rs1 : m[c][0].rs2;
        us = (src == 0) ? m[c][0].u1 : m[c][0].u2;
        if (!us || s == 0) return 0;
        for (int k = 1; k < C_STAGES[c]; k++)
            if (prod(c, k, s)) return k;
        return 0;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < 8; i++) m[c][i] = '{default: 0};
            m_sc[c] = 0;
            m_fc[c] = 0;
        end
    endtask

    task automatic model_update();
        bit st, fl;
        int mx;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (busy) return;
        for (int c = 0; c < NC; c++) begin
            st = mdl_stall(c);
            fl = bt;
            mx = (1 << C_CNTW[c]) - 1;
            for (int k = C_STAGES[c] - 1; k >= 1; k--) begin
                m[c][k] = m[c][k-1];
                if (fl && (k - 1) < C_BR[c]) m[c][k].v = 1'b0;
            end
            m[c][0] = '{v: id_valid && !st && !fl, rd: int'(rd), wr: wr, ld: ld,
                        rs1: int'(rs1), rs2: int'(rs2), u1: u1, u2: u2};
            if (st && m_sc[c] < mx) m_sc[c]++;
            if (fl && m_fc[c] < mx) m_fc[c]++;
        end
    endtask

    task automatic chk(string nm, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // inputs for this cycle are already applied; record expectation, then clock
    task automatic step();
        exp_t e;
        if (!rst_n) model_clear();
        for (int c = 0; c < NC; c++) begin
            e.st[c] = mdl_stall(c);
            e.fl[c] = rst_n & bt;
            e.fa[c] = 3'(mdl_fwd(c, 0));
            e.fb[c] = 3'(mdl_fwd(c, 1));
            e.sc[c] = 16'(m_sc[c]);
            e.fc[c] = 16'(m_fc[c]);
        end
        q.push_back(e);
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic set_id(bit v, int d, bit w, bit l, int s1, bit uu1, int s2, bit uu2);
        id_valid = v; rd = 5'(d); wr = w; ld = l;
        rs1 = 5'(s1); u1 = uu1; rs2 = 5'(s2); u2 = uu2;
    endtask

    task automatic nops(int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    // hold the instruction in ID while the default-config model predicts a stall
    task automatic issue(int d, bit w, bit l, int s1, bit uu1, int s2, bit uu2);
        int guard = 0;
        set_id(1, d, w, l, s1, uu1, s2, uu2);
        step();
        while (mdl_stall(0) && guard < 8) begin
            step();
            guard++;
        end
    endtask

    // monitor: DUT outputs are presented every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int c = 0; c < NC; c++) begin
                    chk($sformatf("d%0d STALL", c), int'(a_st[c]), int'(e.st[c]));
                    chk($sformatf("d%0d FLUSH", c), int'(a_fl[c]), int'(e.fl[c]));
                    chk($sformatf("d%0d FWD_A", c), int'(a_fa[c]), int'(e.fa[c]));
                    chk($sformatf("d%0d FWD_B", c), int'(a_fb[c]), int'(e.fb[c]));
                    chk($sformatf("d%0d STALL_CNT", c), int'(a_sc[c]), int'(e.sc[c]));
                    chk($sformatf("d%0d FLUSH_CNT", c), int'(a_fc[c]), int'(e.fc[c]));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        model_clear();
        @(posedge CLK); #1;
        // reset with a dependent-looking ID instruction present
        set_id(1, 3, 1, 1, 3, 1, 3, 1); bt = 1'b1;
        repeat (2) step();
        bt = 1'b0; rst_n = 1'b1;
        nops(2);

        // forwarding distance 1, 2 and 3 (none)
        issue(5, 1, 0, 1, 1, 2, 1); issue(6, 1, 0, 5, 1, 1, 1); nops(4);
        issue(5, 1, 0, 1, 1, 2, 1); nops(1); issue(6, 1, 0, 5, 1, 1, 1); nops(4);
        issue(5, 1, 0, 1, 1, 2, 1); nops(2); issue(6, 1, 0, 5, 1, 1, 1); nops(4);
        // load-use on both operands
        issue(7, 1, 1, 1, 1, 0, 0); issue(8, 1, 0, 7, 1, 7, 1); nops(4);
        // back-to-back ALU dependency on both operands
        issue(5, 1, 0, 1, 1, 0, 0); issue(9, 1, 0, 5, 1, 5, 1); nops(4);
        // writes to x0 never create hazards
        issue(0, 1, 1, 1, 1, 0, 0); issue(4, 1, 0, 0, 1, 0, 1); nops(4);
        // taken branch with a dependent instruction in ID
        issue(5, 1, 1, 1, 1, 0, 0);
        set_id(1, 6, 1, 0, 5, 1, 5, 1); bt = 1'b1; step(); bt = 1'b0;
        nops(4);

        // BUSYWAIT freeze during a load-use stall
        issue(7, 1, 1, 1, 1, 0, 0);
        set_id(1, 8, 1, 0, 7, 1, 7, 1); step();
        busy = 1'b1; repeat (5) step();
        bt = 1'b1; step(); step();
        busy = 1'b0; step(); bt = 1'b0;
        repeat (3) step();
        nops(4);

        // counter saturation on the narrow-counter instance
        bt = 1'b1; repeat (6) step(); bt = 1'b0;
        issue(7, 1, 1, 1, 1, 0, 0);
        repeat (5) begin set_id(1, 8, 1, 0, 7, 1, 0, 0); step(); end
        nops(3);

        // reset mid-run with producers in flight, then a consumer after release
        issue(5, 1, 0, 1, 1, 0, 0); issue(6, 1, 1, 1, 1, 0, 0);
        set_id(1, 9, 1, 0, 5, 1, 6, 1); rst_n = 1'b0; step(); step();
        rst_n = 1'b1; step(); step();
        nops(3);

        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            busy  = ($urandom_range(0, 99) < 15);
            bt    = ($urandom_range(0, 99) < 10);
            set_id($urandom_range(0, 99) < 80, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1));
            step();
        end
        rst_n = 1'b1; busy = 1'b0; bt = 1'b0;
        nops(4);

        repeat (3) @(negedge CLK);
        #1;
        chk("scoreboard drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
